// File: rtl/branch_cmp_pipe_pkg.sv
// Shared CPU definitions: branch compare opcodes and the compare result payload.
package branch_cmp_pipe_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_EQ  = 3'd0,
    OP_NE  = 3'd1,
    OP_LEZ = 3'd2,
    OP_GTZ = 3'd3,
    OP_LTZ = 3'd4,
    OP_GEZ = 3'd5,
    OP_LT  = 3'd6,
    OP_LTU = 3'd7
  } op_e;

  typedef struct packed {
    logic taken;
    logic eq;
    logic eqz;
    logic ltz;
    logic gtz;
  } cmp_res_t;

  localparam int unsigned RES_W = $bits(cmp_res_t);

endpackage

// File: rtl/branch_cmp_pipe_cmp_core.sv
// Combinational branch comparator: operand flags plus the op-selected taken bit.
module cmp_core
  import branch_cmp_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [OP_W-1:0]  op,
  output logic             eq,
  output logic             eqz,
  output logic             ltz,
  output logic             gtz,
  output logic             taken
);

  logic w_lt;
  logic w_ltu;

  assign eq    = (in1 == in2);
  assign eqz   = (in1 == '0);
  assign ltz   = in1[WIDTH-1];
  assign gtz   = ~ltz & ~eqz;
  assign w_lt  = ($signed(in1) < $signed(in2));
  assign w_ltu = (in1 < in2);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_EQ:   taken = eq;
      OP_NE:   taken = ~eq;
      OP_LEZ:  taken = ltz | eqz;
      OP_GTZ:  taken = gtz;
      OP_LTZ:  taken = ltz;
      OP_GEZ:  taken = ~ltz;
      OP_LT:   taken = w_lt;
      OP_LTU:  taken = w_ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined branch comparator with stall/flush control and a saturating
// count of retired taken results.
module branch_cmp_pipe
  import branch_cmp_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             taken,
  output logic             eq,
  output logic             eqz,
  output logic             ltz,
  output logic             gtz,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cmp_res_t w_res;

  cmp_core #(.WIDTH(WIDTH)) u_cmp_core (
    .in1   (in1),
    .in2   (in2),
    .op    (op),
    .eq    (w_res.eq),
    .eqz   (w_res.eqz),
    .ltz   (w_res.ltz),
    .gtz   (w_res.gtz),
    .taken (w_res.taken)
  );

  // Index 0 is the live compare result; index g is the output of stage g.
  cmp_res_t [STAGES:0] w_data;
  logic     [STAGES:0] w_vld;

  assign w_vld[0]  = in_valid;
  assign w_data[0] = w_res;

  genvar g;
  generate
    for (g = 1; g <= STAGES; g++) begin : g_stage
      cmp_res_t r_data;
      logic     r_vld;

      // Bubbles load zero flags so the last stage drives 0 whenever invalid.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          r_vld  <= 1'b0;
          r_data <= '0;
        end else if (!stall) begin
          r_vld  <= w_vld[g-1];
          r_data <= w_vld[g-1] ? w_data[g-1] : '0;
        end
      end

      assign w_vld[g]  = r_vld;
      assign w_data[g] = r_data;
    end
  endgenerate

  assign out_valid = w_vld[STAGES];
  assign taken     = w_data[STAGES].taken;
  assign eq        = w_data[STAGES].eq;
  assign eqz       = w_data[STAGES].eqz;
  assign ltz       = w_data[STAGES].ltz;
  assign gtz       = w_data[STAGES].gtz;

  logic             w_retire;
  logic [CNT_W-1:0] r_cnt;

  assign w_retire = w_vld[STAGES] & ~stall & ~flush;

  // Clear beats a same-cycle increment; the count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_retire && w_data[STAGES].taken && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign taken_cnt = r_cnt;

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Scoreboard bench for branch_cmp_pipe: directed scenarios plus random traffic.
module tb_branch_cmp_pipe;
  import branch_cmp_pipe_pkg::*;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, in_valid, stall, flush, cnt_clr;
  logic [2:0]       op;
  logic [WIDTH-1:0] in1, in2;
  logic             out_valid, taken, eq, eqz, ltz, gtz;
  logic [CNT_W-1:0] taken_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0] res;  // {taken, eq, eqz, ltz, gtz}
    int         age;  // unstalled edges since accept, -1 before the accept edge
  } ent_t;

  ent_t exp_q[$];
  int   m_cnt = 0;

  always #5 clk = ~clk;

  branch_cmp_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .stall     (stall),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .out_valid (out_valid),
    .taken     (taken),
    .eq        (eq),
    .eqz       (eqz),
    .ltz       (ltz),
    .gtz       (gtz),
    .taken_cnt (taken_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: branch rules straight from the opcode table.
  function automatic logic [4:0] ref_res(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    longint sa, sb;
    logic   t, e, z, n, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = (a == b);
    z  = (sa == 0);
    n  = (sa < 0);
    p  = (sa > 0);
    case (o)
      3'd0: t = e;
      3'd1: t = !e;
      3'd2: t = (sa <= 0);
      3'd3: t = p;
      3'd4: t = n;
      3'd5: t = (sa >= 0);
      3'd6: t = (sa < sb);
      default: t = (longint'({32'd0, a}) < longint'({32'd0, b}));
    endcase
    return {t, e, z, n, p};
  endfunction

  // One clock: drive at negedge, record an expected result if this edge accepts.
  task automatic cyc(input logic v, input logic [2:0] o, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input logic st, input logic fl,
                     input logic clr, input logic rst);
    ent_t e;
    reset = rst; in_valid = v; op = o; in1 = a; in2 = b;
    stall = st; flush = fl; cnt_clr = clr;
    if (v && !st && !fl && !rst) begin
      e.res = ref_res(o, a, b);
      e.age = -1;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(WIDTH-1){1'b0}}};
      3: return WIDTH'($urandom_range(0, 3));
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Monitor: advance the model on each edge, then compare the settled outputs.
  initial begin
    ent_t        e;
    logic [4:0]  exp_flags;
    logic        exp_vld;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        exp_q.delete();
        m_cnt = 0;
      end else if (flush) begin
        exp_q.delete();
        if (cnt_clr) m_cnt = 0;
      end else if (stall) begin
        if (cnt_clr) m_cnt = 0;
      end else begin
        if (exp_q.size() > 0 && exp_q[0].age == STAGES - 1) begin
          e = exp_q.pop_front();
          if (e.res[4] && m_cnt < CNT_SAT) m_cnt++;
        end
        if (cnt_clr) m_cnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
          e = exp_q[i];
          e.age++;
          exp_q[i] = e;
        end
      end
      exp_vld   = (exp_q.size() > 0) && (exp_q[0].age == STAGES - 1);
      exp_flags = exp_vld ? exp_q[0].res : 5'b0;
      chk("out_valid", 64'(out_valid), 64'(exp_vld));
      chk("flags", 64'({taken, eq, eqz, ltz, gtz}), 64'(exp_flags));
      chk("taken_cnt", 64'(taken_cnt), 64'(m_cnt));
    end
  end

  initial begin
    // Reset, then a single EQ 5==5 result.
    cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_cnt", 64'(taken_cnt), 64'd0);
    cyc(1'b1, OP_EQ, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("eq5_valid", 64'({out_valid, taken, eq, gtz}), 64'hF);
    cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("eq5_cnt", 64'(taken_cnt), 64'd1);
    idle(2);

    // Signed vs unsigned with -1 and 1.
    cyc(1'b1, OP_LT,  32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_LTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_LTZ, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // One accept, then a three-cycle stall with input presented.
    cyc(1'b1, OP_GEZ, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, OP_EQ, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Two back-to-back accepts, then flush with stall.
    cyc(1'b1, OP_NE, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_NE, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_NE, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    idle(3);

    // Saturation, then clear in a retire cycle.
    for (int i = 0; i < 20; i++) cyc(1'b1, OP_EQ, WIDTH'(i), WIDTH'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("sat_cnt", 64'(taken_cnt), 64'(CNT_SAT));
    cyc(1'b1, OP_EQ, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_cnt", 64'(taken_cnt), 64'd0);

    // Reset with two results in flight.
    cyc(1'b1, OP_GTZ, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_GTZ, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_GTZ, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(taken_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_no_late", 64'(out_valid), 64'd0);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [WIDTH-1:0] a, b;
      a = pick_operand();
      b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
      cyc(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), a, b,
          1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_cmp_pipe.md
BRANCH_CMP_PIPE -- requirements
Module: branch_cmp_pipe

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter STAGES, default 1, giving the number of result register stages (legal range 1..3).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the taken-event counter.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have one clock and one reset; reset is synchronous and active-high:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
REQ-005 It SHALL have the following ports:
- in_valid  in  1  operands/op valid this cycle
- op  in  3  compare mode
- in1  in  WIDTH  operand 1
- in2  in  WIDTH  operand 2
- stall  in  1  freeze whole pipeline
- flush  in  1  kill all in-flight results
- cnt_clr  in  1  clear taken counter
- out_valid  out  1  result valid
- taken  out  1  mode-selected result
- eq  out  1  in1 == in2
- eqz  out  1  in1 == 0
- ltz  out  1  in1 < 0 (signed)
- gtz  out  1  in1 > 0 (signed)
- taken_cnt  out  CNT_W  saturating count of retired taken results

Function
REQ-006 op encoding SHALL be:
- 0 EQ: eq
- 1 NE: !eq
- 2 LEZ: ltz|eqz
- 3 GTZ: gtz
- 4 LTZ: ltz
- 5 GEZ: !ltz
- 6 LT: signed in1<in2
- 7 LTU: unsigned in1<in2
REQ-007 Flags and taken SHALL be computed combinationally from in1/in2/op and captured into stage 1 on accept; stages 2..STAGES SHALL be pure delay registers.
REQ-008 Accept SHALL occur when in_valid=1, stall=0 and flush=0.
REQ-009 With no stall, a result accepted at edge N SHALL appear on the outputs (out_valid=1) after edge N+STAGES-1, i.e. exactly STAGES cycles after it was presented.
REQ-010 A stage SHALL load an invalid bubble (valid=0, flags held don't-care) when its upstream source is not valid.
REQ-011 While stall=1 and flush=0, every stage register and its valid bit SHALL hold its value, and the input SHALL be ignored.
REQ-012 flush=1 SHALL clear every valid bit at the next edge, overriding both stall and in_valid; the presented input SHALL be dropped.
REQ-013 When out_valid=0, the flag outputs SHALL be driven 0.
REQ-014 A result SHALL retire in any cycle with out_valid=1, stall=0 and flush=0.
REQ-015 taken_cnt SHALL increment by 1 on retirement of a result with taken=1, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-016 cnt_clr=1 SHALL zero taken_cnt at the next edge; on a same-cycle increment, clear SHALL win.
REQ-017 stall SHALL NOT affect cnt_clr.
REQ-018 Operands SHALL be treated as two's complement for LEZ/GTZ/LTZ/GEZ/LT, and as unsigned for LTU.

Reset
REQ-019 reset=1 SHALL, at the clock edge, clear all valid bits, stage flags and taken_cnt to 0; reset SHALL override stall, flush and cnt_clr.
REQ-020 Reset asserted mid-operation SHALL discard every in-flight result, with no retirement counted in that cycle.
REQ-021 out_valid SHALL be 0 in the first cycle after reset deasserts.

Structure
REQ-022 The op encodings (3-bit) SHALL be named constants in the shared CPU definitions package, which the decoder also uses.
REQ-023 The combinational compare logic SHALL be a sub-module cmp_core (in1, in2, op -> eq, eqz, ltz, gtz, taken); the pipeline and counter SHALL live in branch_cmp_pipe.
REQ-024 The stages SHALL be a generate-loop register array indexed 1..STAGES.

Verification (WIDTH=32, STAGES=2, CNT_W=4)
REQ-025 in1=5, in2=5, op=EQ, one in_valid cycle -> out_valid=1 two cycles later with taken=1, eq=1, gtz=1, and taken_cnt=1 the cycle after.
REQ-026 in1=0xFFFFFFFF, in2=1 -> op=LT gives taken=1, op=LTU gives taken=0; op=LTZ gives taken=1, ltz=1.
REQ-027 Accept one op, then assert stall for 3 cycles -> outputs frozen and taken_cnt unchanged during the stall; result retires on the first cycle after stall drops.
REQ-028 Two back-to-back accepts, then flush together with stall -> out_valid=0 next cycle, taken_cnt unchanged.
REQ-029 Twenty consecutive taken EQ results -> taken_cnt stops at 15; cnt_clr asserted in a retire cycle -> taken_cnt=0.
REQ-030 reset asserted for one cycle with 2 results in flight -> out_valid=0 and taken_cnt=0; no late result appears afterwards.
